// File: rtl/fs_boot_pkg.sv
// Shared definitions for the UART boot loader: frame constants,
// loader and receiver state encodings.
package fs_boot_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CNT_LO,
      ST_CNT_HI,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } ld_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_BITS,
      RX_STOP
   } rx_state_e;

   function automatic logic in_frame(input ld_state_e s);
      return (s == ST_CNT_LO) || (s == ST_CNT_HI) ||
             (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/fs_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling,
// one-cycle rx_valid on good stop bit, rx_ferr on bad stop bit.
module fs_uart_rx_byte
   import fs_boot_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                uart_rx,
   output logic                rx_valid,
   output logic [BYTE_W-1:0]   rx_byte,
   output logic                rx_ferr
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   rx_state_e         st_q, st_d;
   logic [2:0]        sync_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              valid_q, valid_d;
   logic              ferr_q, ferr_d;
   logic              rx_s, fall;

   // sync_q[1] is the synchronized line, sync_q[2] its previous value
   assign rx_s = sync_q[1];
   assign fall = sync_q[2] & ~sync_q[1];

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (st_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (fall) st_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF) begin
               cnt_d = '0;
               bit_d = '0;
               st_d  = rx_s ? RX_IDLE : RX_BITS;
            end
         end
         RX_BITS: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) st_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               st_d    = RX_IDLE;
               valid_d = rx_s;
               ferr_d  = ~rx_s;
            end
         end
         default: st_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q  <= 3'b111;
         st_q    <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], uart_rx};
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_valid = valid_q;
   assign rx_byte  = shift_q;
   assign rx_ferr  = ferr_q;

endmodule

// File: rtl/fs_uart_boot_loader.sv
// UART boot loader: parses SYNC/COUNT/data/CSUM frames, writes words
// into instruction memory and releases the CPU on a good checksum.
module fs_uart_boot_loader
   import fs_boot_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [31:0] ADDR_BASE    = 32'h0,
   parameter int unsigned MAX_WORDS    = 4096,
   parameter int unsigned TIMEOUT_CYC  = 1048576
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              uart_rx,
   output logic              ins_mem_wenb,
   output logic [WORD_W-1:0] ins_mem_waddr,
   output logic [WORD_W-1:0] ins_mem_wdata,
   output logic              cpu_resetn,
   output logic              load_done,
   output logic              load_err,
   output logic              busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] MAXW = CNT_W'(MAX_WORDS);

   logic              rx_valid, rx_ferr;
   logic [BYTE_W-1:0] rx_byte;

   fs_uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .resetn   (resetn),
      .uart_rx  (uart_rx),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_ferr  (rx_ferr)
   );

   ld_state_e         st_q, st_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_full;
   logic [CNT_W-1:0]  widx_q, widx_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [7:0]        csum_q, csum_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              wenb_q, wenb_d;
   logic [WORD_W-1:0] waddr_q, waddr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              frame;

   assign frame    = in_frame(st_q);
   assign cnt_full = {rx_byte, cnt_q[7:0]};

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      word_d  = word_q;
      csum_d  = csum_q;
      tmo_d   = '0;
      wenb_d  = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (frame && !rx_valid) tmo_d = tmo_q + 1'b1;
      unique case (st_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (rx_valid && rx_byte == SYNC_BYTE) st_d = ST_CNT_LO;
         end
         ST_CNT_LO: begin
            if (rx_valid) begin
               cnt_d[7:0] = rx_byte;
               st_d       = ST_CNT_HI;
            end
         end
         ST_CNT_HI: begin
            if (rx_valid) begin
               cnt_d  = cnt_full;
               widx_d = '0;
               bidx_d = '0;
               csum_d = '0;
               if (cnt_full == '0 || cnt_full > MAXW) st_d = ST_ERR;
               else st_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_valid) begin
               word_d[{bidx_q, 3'b000} +: 8] = rx_byte;
               csum_d = csum_q ^ rx_byte;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  wenb_d  = 1'b1;
                  waddr_d = ADDR_BASE + {14'b0, widx_q, 2'b00};
                  wdata_d = word_d;
                  widx_d  = widx_q + 16'd1;
                  if (widx_q == cnt_q - 16'd1) st_d = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            if (rx_valid) st_d = (rx_byte == csum_q) ? ST_DONE : ST_ERR;
         end
         default: st_d = ST_IDLE;
      endcase
      // Framing error or a stalled sender abandons the frame
      if (frame && (rx_ferr || (!rx_valid && tmo_q == TMO_LAST)))
         st_d = ST_ERR;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q    <= ST_IDLE;
         cnt_q   <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
         csum_q  <= '0;
         tmo_q   <= '0;
         wenb_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         csum_q  <= csum_d;
         tmo_q   <= tmo_d;
         wenb_q  <= wenb_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign ins_mem_wenb  = wenb_q;
   assign ins_mem_waddr = waddr_q;
   assign ins_mem_wdata = wdata_q;
   assign cpu_resetn    = (st_q == ST_DONE);
   assign load_done     = (st_q == ST_DONE);
   assign load_err      = (st_q == ST_ERR);
   assign busy          = frame;

endmodule
